// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller: multi-cycle load-use stall, branch flush, memory freeze
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic              stall_active,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {IDLE, LU_STALL} state_t;

  localparam logic [2:0]       LAT_M1  = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [2:0]       rem;
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             hz;

  // $zero is hardwired, so a load targeting it can never create a dependency
  assign hz = id_ex_memread && (id_ex_rt != '0) &&
              ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_freeze = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if ((state == LU_STALL) || hz) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  assign stall_active = !reset && (state == LU_STALL);
  assign lu_stall_cnt = reset ? '0 : lu_cnt_q;
  assign flush_cnt    = reset ? '0 : flush_cnt_q;

  // mem_busy holds everything: EX is frozen, so branch/hazard re-present next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= 3'd0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else if (!mem_busy) begin
      if (branch_taken) begin
        state <= IDLE;
        rem   <= 3'd0;
        if (flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (state == LU_STALL) begin
        if (lu_cnt_q != CNT_MAX) lu_cnt_q <= lu_cnt_q + 1'b1;
        rem <= rem - 3'd1;
        if (rem == 3'd1) state <= IDLE;
      end else if (hz) begin
        if (lu_cnt_q != CNT_MAX) lu_cnt_q <= lu_cnt_q + 1'b1;
        rem   <= LAT_M1;
        state <= (LOAD_LAT > 1) ? LU_STALL : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - randomized and directed check of hazard_ctrl_unit against a cycle-count model
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       if_id_uses_rt, branch_taken, mem_busy;

  logic        pcw[3], ifw[3], flu[3], bub[3], frz[3], sac[3];
  logic [15:0] luc0, flc0, luc1, flc1;
  logic [3:0]  luc2, flc2;

  int n_cmp = 0;
  int n_bad = 0;

  int lat[3]  = '{1, 3, 3};
  int cmax[3] = '{65535, 65535, 15};
  int left[3];
  int lu[3];
  int fl[3];

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pcw[0]),
    .if_id_write(ifw[0]), .if_id_flush(flu[0]), .id_ex_bubble(bub[0]),
    .pipe_freeze(frz[0]), .stall_active(sac[0]), .lu_stall_cnt(luc0), .flush_cnt(flc0));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pcw[1]),
    .if_id_write(ifw[1]), .if_id_flush(flu[1]), .id_ex_bubble(bub[1]),
    .pipe_freeze(frz[1]), .stall_active(sac[1]), .lu_stall_cnt(luc1), .flush_cnt(flc1));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pcw[2]),
    .if_id_write(ifw[2]), .if_id_flush(flu[2]), .id_ex_bubble(bub[2]),
    .pipe_freeze(frz[2]), .stall_active(sac[2]), .lu_stall_cnt(luc2), .flush_cnt(flc2));

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned dut_lu(input int i);
    return (i == 0) ? int'(luc0) : (i == 1) ? int'(luc1) : int'(luc2);
  endfunction

  function automatic int unsigned dut_fl(input int i);
    return (i == 0) ? int'(flc0) : (i == 1) ? int'(flc1) : int'(flc2);
  endfunction

  // Model: a load-use hazard costs LOAD_LAT non-frozen cycles; 'left' counts what remains after the first
  task automatic step(input logic r, input logic mr, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic u, input logic br, input logic mb);
    bit hz;
    bit e_pcw, e_ifw, e_flu, e_bub, e_frz, e_sac;
    @(negedge clk);
    reset = r; id_ex_memread = mr; id_ex_rt = a; if_id_rs = b; if_id_rt = c;
    if_id_uses_rt = u; branch_taken = br; mem_busy = mb;
    #1;
    hz = mr && (a != 0) && ((a == b) || (u && (a == c)));
    for (int i = 0; i < 3; i++) begin
      e_pcw = 1; e_ifw = 1; e_flu = 0; e_bub = 0; e_frz = 0;
      e_sac = !r && (left[i] > 0);
      if (!r) begin
        if (mb) begin
          e_pcw = 0; e_ifw = 0; e_frz = 1;
        end else if (br) begin
          e_flu = 1; e_bub = 1;
        end else if (left[i] > 0 || hz) begin
          e_pcw = 0; e_ifw = 0; e_bub = 1;
        end
      end
      check($sformatf("ctl[%0d]", i), {pcw[i], ifw[i], flu[i], bub[i], frz[i], sac[i]},
            {e_pcw, e_ifw, e_flu, e_bub, e_frz, e_sac});
      check($sformatf("lu_cnt[%0d]", i), dut_lu(i), r ? 0 : lu[i]);
      check($sformatf("flush_cnt[%0d]", i), dut_fl(i), r ? 0 : fl[i]);
      if (r) begin
        left[i] = 0; lu[i] = 0; fl[i] = 0;
      end else if (!mb) begin
        if (br) begin
          left[i] = 0;
          if (fl[i] < cmax[i]) fl[i]++;
        end else if (left[i] > 0 || hz) begin
          if (lu[i] < cmax[i]) lu[i]++;
          left[i] = (left[i] > 0) ? left[i] - 1 : lat[i] - 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin left[i] = 0; lu[i] = 0; fl[i] = 0; end
    reset = 1; id_ex_memread = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_uses_rt = 0; branch_taken = 0; mem_busy = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // single load-use hazard on rs
    step(0, 1, 8, 8, 0, 0, 0, 0);
    idle(4);
    check("lat1_lu_total", luc0, 1);
    check("lat3_lu_total", luc1, 3);

    // $zero and an unused rt never stall
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 9, 1, 9, 0, 0, 0);
    check("no_stall_pcw", pcw[1], 1);
    step(0, 1, 9, 1, 9, 1, 0, 0);
    idle(3);

    // branch on the second stall cycle cancels the stall
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8, 8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    check("branch_lu", luc1, 1);
    check("branch_fl", flc1, 1);

    // memory freeze in the middle of a stall
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8, 8, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(4);
    check("freeze_lu", luc1, 3);

    // reset mid-stall aborts it
    step(0, 1, 3, 3, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    check("rst_abort_sac", sac[1], 0);

    // flush counter saturation on the 4-bit instance
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check("flush_sat", flc2, 15);

    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 99) < 2), $urandom_range(0, 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
